// File: rtl/mycpu_exe_stage_if.sv
// ---------------------------------------------------------------------------
// Bundles that connect the MIPS execute stage to its neighbours.
//
// Handshake rule for both pipeline bundles: an instruction moves across a
// boundary on a rising clock edge only when the producer's valid and the
// consumer's allowin are both high in the cycle before that edge. allowin
// may be high with valid low. valid must not be withdrawn by the producer
// while it is waiting, except when a flush kills the instruction.
//
// mycpu_ds_es_if : decode -> execute (master = decode, slave = execute)
//   ds_to_es_valid, ds_* fields         master -> slave
//   es_allowin, es_fwd_dest             slave  -> master
// mycpu_es_ms_if : execute -> memory (master = execute, slave = memory)
//   es_to_ms_valid, es_* fields         master -> slave
//   ms_allowin                          slave  -> master
// mycpu_data_sram_if : execute -> data SRAM request (master = execute)
//   data_sram_en/wen/addr/wdata         master -> slave
// ---------------------------------------------------------------------------
interface mycpu_ds_es_if #(parameter int DATA_WIDTH = 32);
    logic                  ds_to_es_valid;
    logic                  es_allowin;
    logic [DATA_WIDTH-1:0] ds_pc;
    logic [3:0]            ds_alu_op;
    logic                  ds_src1_is_sa;
    logic                  ds_src2_is_imm;
    logic                  ds_imm_zext;
    logic [15:0]           ds_imm;
    logic [DATA_WIDTH-1:0] ds_rs_value;
    logic [DATA_WIDTH-1:0] ds_rt_value;
    logic                  ds_ov_en;
    logic                  ds_mem_re;
    logic                  ds_mem_we;
    logic [4:0]            ds_dest;
    logic [4:0]            es_fwd_dest;

    modport master (
        output ds_to_es_valid, ds_pc, ds_alu_op, ds_src1_is_sa, ds_src2_is_imm,
               ds_imm_zext, ds_imm, ds_rs_value, ds_rt_value, ds_ov_en,
               ds_mem_re, ds_mem_we, ds_dest,
        input  es_allowin, es_fwd_dest
    );
    modport slave (
        input  ds_to_es_valid, ds_pc, ds_alu_op, ds_src1_is_sa, ds_src2_is_imm,
               ds_imm_zext, ds_imm, ds_rs_value, ds_rt_value, ds_ov_en,
               ds_mem_re, ds_mem_we, ds_dest,
        output es_allowin, es_fwd_dest
    );
endinterface

interface mycpu_es_ms_if #(parameter int DATA_WIDTH = 32);
    logic                  es_to_ms_valid;
    logic                  ms_allowin;
    logic [DATA_WIDTH-1:0] es_pc;
    logic [DATA_WIDTH-1:0] es_result;
    logic [4:0]            es_dest;
    logic                  es_mem_re;
    logic                  es_ex;
    logic [4:0]            es_excode;

    modport master (
        output es_to_ms_valid, es_pc, es_result, es_dest, es_mem_re, es_ex, es_excode,
        input  ms_allowin
    );
    modport slave (
        input  es_to_ms_valid, es_pc, es_result, es_dest, es_mem_re, es_ex, es_excode,
        output ms_allowin
    );
endinterface

interface mycpu_data_sram_if #(parameter int DATA_WIDTH = 32);
    logic                  data_sram_en;
    logic [3:0]            data_sram_wen;
    logic [DATA_WIDTH-1:0] data_sram_addr;
    logic [DATA_WIDTH-1:0] data_sram_wdata;

    modport master (output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata);
    modport slave  (input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata);
endinterface

// File: rtl/mycpu_exe_stage.sv
// ---------------------------------------------------------------------------
// Execute stage of the five-stage MIPS pipeline, plus its ALU.
//
// mycpu_exe_stage
//   clk, reset : clock, asynchronous active-high reset
//   flush      : exception/eret flush from writeback, kills the held instr
//   ds         : decode bundle (slave)   - instruction in, allowin/fwd out
//   ms         : memory bundle (master)  - result/dest/exception out
//   sram       : data-SRAM request (master)
// Single-cycle stage: an accepted instruction is offered downstream from the
// next cycle until the memory stage takes it. Only DATA_WIDTH = 32 is
// meaningful (MIPS32 immediates and shift amounts).
//
// myCPU_alu
//   A, B     : operands (B is the value shifted, A[4:0] the amount)
//   ALUop    : 0000 ADDU 0001 SUBU 1100 ADD 1101 SUB 0010 SLT 0011 SLTU
//              0100 AND 0101 OR 0110 XOR 0111 NOR 1000 SLL 1010 SRL 1011 SRA
//   result   : ALU result (0 for unused codes)
//   overFlow : signed overflow of the add/sub being performed
// The stage has no use for zero/carry, so the ALU does not produce them.
// ---------------------------------------------------------------------------
module myCPU_alu (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  ALUop,
    output logic [31:0] result,
    output logic        overFlow
);
    logic [31:0] sum;
    logic [31:0] diff;
    logic        is_add;
    logic        is_sub;

    assign sum    = A + B;
    assign diff   = A - B;
    assign is_add = (ALUop == 4'b0000) || (ALUop == 4'b1100);
    assign is_sub = (ALUop == 4'b0001) || (ALUop == 4'b1101);

    // Signed overflow: operands with the same sign (add) or opposite signs
    // (sub) giving a result whose sign differs from A.
    always_comb begin
        overFlow = 1'b0;
        if (is_add)
            overFlow = (A[31] == B[31]) && (sum[31] != A[31]);
        else if (is_sub)
            overFlow = (A[31] != B[31]) && (diff[31] != A[31]);
    end

    always_comb begin
        result = 32'h0;
        case (ALUop)
            4'b0000, 4'b1100: result = sum;
            4'b0001, 4'b1101: result = diff;
            4'b0010:          result = {31'b0, $signed(A) < $signed(B)};
            4'b0011:          result = {31'b0, A < B};
            4'b0100:          result = A & B;
            4'b0101:          result = A | B;
            4'b0110:          result = A ^ B;
            4'b0111:          result = ~(A | B);
            4'b1000:          result = B << A[4:0];
            4'b1010:          result = B >> A[4:0];
            4'b1011:          result = $unsigned($signed(B) >>> A[4:0]);
            default:          result = 32'h0;
        endcase
    end
endmodule

module mycpu_exe_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    mycpu_ds_es_if.slave      ds,
    mycpu_es_ms_if.master     ms,
    mycpu_data_sram_if.master sram
);
    localparam logic [4:0] EXC_OV   = 5'h0C;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;

    logic                  es_valid;
    logic                  es_allowin;
    logic [DATA_WIDTH-1:0] pc_r;
    logic [3:0]            alu_op_r;
    logic                  src1_is_sa_r;
    logic                  src2_is_imm_r;
    logic                  imm_zext_r;
    logic [15:0]           imm_r;
    logic [DATA_WIDTH-1:0] rs_value_r;
    logic [DATA_WIDTH-1:0] rt_value_r;
    logic                  ov_en_r;
    logic                  mem_re_r;
    logic                  mem_we_r;
    logic [4:0]            dest_r;

    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_ov;
    logic                  ov;
    logic                  ade;
    logic                  es_ex;
    logic                  mem_access;

    // es_ready_go is constant 1, so the stage frees up whenever the memory
    // stage takes the held instruction.
    assign es_allowin    = !es_valid || ms.ms_allowin;
    assign ds.es_allowin = es_allowin;

    // Flush wins over any handshake: the held instruction dies and nothing
    // new is taken on that edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            es_valid <= 1'b0;
        else if (flush)
            es_valid <= 1'b0;
        else if (es_allowin)
            es_valid <= ds.ds_to_es_valid;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r          <= '0;
            alu_op_r      <= '0;
            src1_is_sa_r  <= 1'b0;
            src2_is_imm_r <= 1'b0;
            imm_zext_r    <= 1'b0;
            imm_r         <= '0;
            rs_value_r    <= '0;
            rt_value_r    <= '0;
            ov_en_r       <= 1'b0;
            mem_re_r      <= 1'b0;
            mem_we_r      <= 1'b0;
            dest_r        <= '0;
        end else if (es_allowin && ds.ds_to_es_valid && !flush) begin
            pc_r          <= ds.ds_pc;
            alu_op_r      <= ds.ds_alu_op;
            src1_is_sa_r  <= ds.ds_src1_is_sa;
            src2_is_imm_r <= ds.ds_src2_is_imm;
            imm_zext_r    <= ds.ds_imm_zext;
            imm_r         <= ds.ds_imm;
            rs_value_r    <= ds.ds_rs_value;
            rt_value_r    <= ds.ds_rt_value;
            ov_en_r       <= ds.ds_ov_en;
            mem_re_r      <= ds.ds_mem_re;
            mem_we_r      <= ds.ds_mem_we;
            dest_r        <= ds.ds_dest;
        end
    end

    // Operand formation: the shift amount lives in imm[10:6] (the sa field).
    assign alu_a = src1_is_sa_r ? {{(DATA_WIDTH-5){1'b0}}, imm_r[10:6]} : rs_value_r;
    assign alu_b = src2_is_imm_r
                 ? (imm_zext_r ? {{(DATA_WIDTH-16){1'b0}}, imm_r}
                               : {{(DATA_WIDTH-16){imm_r[15]}}, imm_r})
                 : rt_value_r;

    myCPU_alu u_alu (
        .A        (alu_a),
        .B        (alu_b),
        .ALUop    (alu_op_r),
        .result   (alu_result),
        .overFlow (alu_ov)
    );

    // Only word accesses exist, so any non-zero low address bit is an
    // address error. Decode never sets ov_en together with a memory access;
    // if it did, Ov takes precedence in the code below.
    assign mem_access = mem_re_r || mem_we_r;
    assign ov         = es_valid && ov_en_r && alu_ov;
    assign ade        = es_valid && mem_access && (alu_result[1:0] != 2'b00);
    assign es_ex      = ov || ade;

    always_comb begin
        ms.es_excode = 5'h00;
        if (ov)
            ms.es_excode = EXC_OV;
        else if (ade && mem_re_r)
            ms.es_excode = EXC_ADEL;
        else if (ade)
            ms.es_excode = EXC_ADES;
    end

    assign ms.es_to_ms_valid = es_valid && !flush;
    assign ms.es_pc          = pc_r;
    // Result passes through unchanged under exceptions: it is BadVAddr.
    assign ms.es_result      = alu_result;
    assign ms.es_dest        = es_ex ? 5'd0 : dest_r;
    assign ms.es_mem_re      = mem_re_r && !es_ex;
    assign ms.es_ex          = es_ex;
    assign ds.es_fwd_dest    = es_valid ? ms.es_dest : 5'd0;

    // The request is tied to the transfer cycle, so a stalled access issues
    // exactly once, in the cycle the memory stage accepts it.
    assign sram.data_sram_en    = es_valid && mem_access && !es_ex && !flush && ms.ms_allowin;
    assign sram.data_sram_wen   = {4{sram.data_sram_en && mem_we_r}};
    assign sram.data_sram_addr  = {alu_result[DATA_WIDTH-1:2], 2'b00};
    assign sram.data_sram_wdata = rt_value_r;
endmodule
